// File: rtl/rover_pkg.sv
// Shared rover motion types: arbiter state, H-bridge coast pattern, and the
// shoot-through check applied to every proposed H-bridge pattern.
package rover_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_DEAD = 2'd3
  } arb_state_e;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  localparam logic [3:0] HB_COAST = 4'b0000;

  // A leg with both switches on shorts the supply.
  function automatic logic shoot_through(input logic [3:0] ins);
    return (ins[1:0] == 2'b11) || (ins[3:2] == 2'b11);
  endfunction

  function automatic logic [3:0] safe_drive(input logic [3:0] ins);
    return shoot_through(ins) ? HB_COAST : ins;
  endfunction

endpackage

// File: rtl/dead_time_counter.sv
// Saturating interval counter: cleared by load, advances while count is high,
// reports done on the last of MAX counted cycles and holds there.
module dead_time_counter #(
  parameter int unsigned MAX = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic count,
  output logic done
);

  localparam int unsigned W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (count && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = count && (cnt_q == LAST);

endmodule

// File: rtl/motion_arbiter.sv
// Forward/reverse H-bridge arbiter with enforced dead time between grants.
// Optional grant watchdog with sticky fault: define MOTION_ARB_WATCHDOG_EN.
module motion_arbiter
  import rover_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 200000,
  parameter int unsigned WD_CYCLES   = 50000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       can_move,
  input  logic       fwd_req,
  input  logic       rev_req,
  input  logic [3:0] fwd_ins,
  input  logic [3:0] rev_ins,
  input  logic       ir_front,
  input  logic       ir_back,
  output logic [3:0] hbridge_ins,
  output logic       fwd_grant,
  output logic       rev_grant,
  output logic       is_moving,
  output logic       fault
);

  if (DEAD_CYCLES == 0 || WD_CYCLES == 0) begin : g_bad_cfg
    $error("motion_arbiter: DEAD_CYCLES and WD_CYCLES must be non-zero");
  end

  arb_state_e state_q, state_d;
  dir_e       last_q, last_d;
  logic [3:0] hb_q, hb_d;
  logic       fwd_grant_q, fwd_grant_d;
  logic       rev_grant_q, rev_grant_d;
  logic       moving_q, moving_d;
  logic       fault_q;
  logic       dead_done;
  logic       wd_trip;
  logic       fwd_hold, rev_hold, fwd_ok, rev_ok;

  assign fwd_hold = can_move && fwd_req && !ir_front;
  assign rev_hold = can_move && rev_req && !ir_back;
  assign fwd_ok   = fwd_hold && !fault_q;
  assign rev_ok   = rev_hold && !fault_q;

  dead_time_counter #(.MAX(DEAD_CYCLES)) u_dead (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (state_q != ST_DEAD),
    .count  (state_q == ST_DEAD),
    .done   (dead_done)
  );

`ifdef MOTION_ARB_WATCHDOG_EN
  logic granted;
  assign granted = (state_q == ST_FWD) || (state_q == ST_REV);

  dead_time_counter #(.MAX(WD_CYCLES)) u_wd (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (!granted),
    .count  (granted),
    .done   (wd_trip)
  );

  // Sticky until reset; blocks every later grant.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else if (wd_trip) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign wd_trip = 1'b0;
  assign fault_q = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      last_q      <= DIR_REV;
      hb_q        <= HB_COAST;
      fwd_grant_q <= 1'b0;
      rev_grant_q <= 1'b0;
      moving_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      hb_q        <= hb_d;
      fwd_grant_q <= fwd_grant_d;
      rev_grant_q <= rev_grant_d;
      moving_q    <= moving_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        // On a tie the direction not served last goes first.
        if (fwd_ok && (!rev_ok || (last_q == DIR_REV))) begin
          state_d = ST_FWD;
          last_d  = DIR_FWD;
        end else if (rev_ok) begin
          state_d = ST_REV;
          last_d  = DIR_REV;
        end
      end
      ST_FWD: begin
        if (!fwd_hold || wd_trip) state_d = ST_DEAD;
      end
      ST_REV: begin
        if (!rev_hold || wd_trip) state_d = ST_DEAD;
      end
      ST_DEAD: begin
        if (dead_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs follow the state being entered so they change on the same edge.
  always_comb begin
    hb_d        = HB_COAST;
    fwd_grant_d = 1'b0;
    rev_grant_d = 1'b0;
    moving_d    = 1'b0;
    case (state_d)
      ST_FWD: begin
        fwd_grant_d = 1'b1;
        moving_d    = 1'b1;
        hb_d        = safe_drive(fwd_ins);
      end
      ST_REV: begin
        rev_grant_d = 1'b1;
        moving_d    = 1'b1;
        hb_d        = safe_drive(rev_ins);
      end
      default: ;
    endcase
  end

  assign hbridge_ins = hb_q;
  assign fwd_grant   = fwd_grant_q;
  assign rev_grant   = rev_grant_q;
  assign is_moving   = moving_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_motion_arbiter.sv
// Scoreboard bench for motion_arbiter: a time-stamp reference model predicts
// outputs per edge; a monitor compares them. Watchdog scenario under MOTION_ARB_WATCHDOG_EN.
module tb_motion_arbiter;

  localparam int DEAD = 8;
  localparam int WD   = 20;
`ifdef MOTION_ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n, can_move, fwd_req, rev_req, ir_front, ir_back;
  logic [3:0] fwd_ins, rev_ins;
  logic [3:0] hbridge_ins;
  logic       fwd_grant, rev_grant, is_moving, fault;

  motion_arbiter #(.DEAD_CYCLES(DEAD), .WD_CYCLES(WD)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .can_move   (can_move),
    .fwd_req    (fwd_req),
    .rev_req    (rev_req),
    .fwd_ins    (fwd_ins),
    .rev_ins    (rev_ins),
    .ir_front   (ir_front),
    .ir_back    (ir_back),
    .hbridge_ins(hbridge_ins),
    .fwd_grant  (fwd_grant),
    .rev_grant  (rev_grant),
    .is_moving  (is_moving),
    .fault      (fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         edge_no;
    logic       fg, rg, mv, flt;
    logic [3:0] hb;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: who owns the bridge, when the next grant may happen.
  int t = 0;
  int owner = 0;          // 0 none, 1 forward, 2 reverse
  int last_dir = 2;
  int grant_edge = 0;
  int earliest = 0;
  bit mfault = 1'b0;

  function automatic logic [3:0] guard(input logic [3:0] p);
    if ((p & 4'b0011) == 4'b0011 || (p & 4'b1100) == 4'b1100) return 4'b0000;
    return p;
  endfunction

  task automatic step(input bit rst_n, input bit cm, input bit fr, input bit rr,
                      input logic [3:0] fi, input logic [3:0] ri,
                      input bit irf, input bit irb);
    exp_t e;
    bit   f_ok, r_ok, keep, wd;
    @(negedge clock);
    reset_n = rst_n; can_move = cm; fwd_req = fr; rev_req = rr;
    fwd_ins = fi; rev_ins = ri; ir_front = irf; ir_back = irb;
    t++;
    f_ok = cm && fr && !irf;
    r_ok = cm && rr && !irb;
    if (!rst_n) begin
      owner = 0; last_dir = 2; mfault = 1'b0; earliest = t + 1;
    end else if (owner != 0) begin
      keep = (owner == 1) ? f_ok : r_ok;
      wd   = WD_EN && (t - grant_edge >= WD);
      if (!keep || wd) begin
        owner = 0;
        earliest = t + DEAD + 1;
        if (wd) mfault = 1'b1;
      end
    end else if (t >= earliest && !mfault) begin
      if (f_ok && r_ok) owner = (last_dir == 1) ? 2 : 1;
      else if (f_ok)    owner = 1;
      else if (r_ok)    owner = 2;
      if (owner != 0) begin
        last_dir = owner;
        grant_edge = t;
      end
    end
    e.edge_no = t;
    e.fg  = (owner == 1);
    e.rg  = (owner == 2);
    e.mv  = (owner != 0);
    e.flt = mfault;
    e.hb  = (owner == 1) ? guard(fi) : (owner == 2) ? guard(ri) : 4'b0000;
    exp_q.push_back(e);
  endtask

  task automatic repeat_step(input int n, input bit rst_n, input bit cm, input bit fr,
                             input bit rr, input logic [3:0] fi, input logic [3:0] ri,
                             input bit irf, input bit irb);
    for (int i = 0; i < n; i++) step(rst_n, cm, fr, rr, fi, ri, irf, irb);
  endtask

  // Monitor: outputs are valid every cycle, checked 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (fwd_grant !== e.fg || rev_grant !== e.rg || is_moving !== e.mv ||
            fault !== e.flt || hbridge_ins !== e.hb) begin
          n_bad++;
          $display("FAIL outputs edge %0d: got fg=%b rg=%b mv=%b flt=%b hb=%b, expected fg=%b rg=%b mv=%b flt=%b hb=%b",
                   e.edge_no, fwd_grant, rev_grant, is_moving, fault, hbridge_ins,
                   e.fg, e.rg, e.mv, e.flt, e.hb);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit cm, fr, rr, irf, irb, rst;
    reset_n = 1'b0; can_move = 1'b0; fwd_req = 1'b0; rev_req = 1'b0;
    fwd_ins = 4'b0; rev_ins = 4'b0; ir_front = 1'b0; ir_back = 1'b0;

    repeat_step(2, 0, 0, 0, 0, 4'b0, 4'b0, 0, 0);
    // Forward grant with one-cycle latency, then hand over to reverse.
    repeat_step(3, 1, 1, 1, 0, 4'b1010, 4'b0101, 0, 0);
    repeat_step(12, 1, 1, 0, 1, 4'b1010, 4'b0101, 0, 0);
    // Tie from reset, forced release by can_move, then alternation.
    repeat_step(1, 0, 0, 0, 0, 4'b0, 4'b0, 0, 0);
    repeat_step(3, 1, 1, 1, 1, 4'b0110, 4'b1001, 0, 0);
    repeat_step(1, 1, 0, 1, 1, 4'b0110, 4'b1001, 0, 0);
    repeat_step(12, 1, 1, 1, 1, 4'b0110, 4'b1001, 0, 0);
    // Shoot-through pattern on reverse, then obstacle behind.
    repeat_step(1, 0, 0, 0, 0, 4'b0, 4'b0, 0, 0);
    repeat_step(3, 1, 1, 0, 1, 4'b0, 4'b0111, 0, 0);
    repeat_step(2, 1, 1, 0, 1, 4'b0, 4'b1100, 0, 0);
    repeat_step(3, 1, 1, 0, 1, 4'b0, 4'b1001, 0, 1);
    // Request re-raised inside dead time, then reset mid-dead.
    repeat_step(4, 1, 1, 1, 0, 4'b1000, 4'b0, 0, 0);
    repeat_step(2, 1, 1, 0, 0, 4'b1000, 4'b0, 0, 0);
    repeat_step(2, 1, 1, 1, 0, 4'b1000, 4'b0, 0, 0);
    repeat_step(1, 0, 1, 1, 0, 4'b1000, 4'b0, 0, 0);
    repeat_step(3, 1, 1, 1, 0, 4'b0100, 4'b0, 0, 0);
    // Obstacle in front blocks a forward request in idle.
    repeat_step(12, 1, 1, 1, 0, 4'b0100, 4'b0, 1, 0);
    repeat_step(2, 1, 1, 1, 0, 4'b0100, 4'b0, 0, 0);
    if (WD_EN) begin
      repeat_step(1, 0, 0, 0, 0, 4'b0, 4'b0, 0, 0);
      repeat_step(25, 1, 1, 1, 0, 4'b0101, 4'b0, 0, 0);
      repeat_step(15, 1, 1, 1, 1, 4'b0101, 4'b1010, 0, 0);
      repeat_step(1, 0, 1, 1, 0, 4'b0101, 4'b0, 0, 0);
      repeat_step(2, 1, 1, 1, 0, 4'b0101, 4'b0, 0, 0);
    end

    // Randomized traffic with sticky requests and occasional resets.
    cm = 1; fr = 0; rr = 0; irf = 0; irb = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)  fr = ~fr;
      if ($urandom_range(7) == 0)  rr = ~rr;
      if ($urandom_range(19) == 0) cm = ~cm;
      if ($urandom_range(15) == 0) irf = ~irf;
      if ($urandom_range(15) == 0) irb = ~irb;
      rst = ($urandom_range(299) == 0);
      step(!rst, cm, fr, rr, 4'($urandom), 4'($urandom), irf, irb);
    end

    @(posedge clock);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
